// File: rtl/sram_pkg.sv
// sram_pkg: definitions shared by the SRAM controller.
//   sram_state_e : controller FSM states
//   SRAM_AW_DEF  : default SRAM half-word address width (256K x 16 part)
//   HALF_LO/HI   : low bit of the SRAM address that selects a half-word
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      ACK  = 2'd3
   } sram_state_e;

   localparam int   SRAM_AW_DEF = 18;
   localparam logic HALF_LO     = 1'b0;
   localparam logic HALF_HI     = 1'b1;

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: LSU-side responder for a 16-bit asynchronous SRAM.
// Splits one 32-bit byte-masked load/store into up to two timed half-word
// accesses (low half, then high half) and returns a one-cycle ack.
// Ports:
//   i_clk, i_rst              clock, async active-high reset
//   i_req/i_wren/i_addr/...   request from LSU; accepted on i_req && o_ready
//   o_ready, o_ack, o_rdata   idle flag, completion pulse, load data
//   o_sram_*, i_sram_dq       SRAM pins (strobes active low)
// All outputs are registered; they are decoded from next-state values so the
// SRAM pins change on the same edge that enters a phase.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int SRAM_AW     = SRAM_AW_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req,
   input  logic               i_wren,
   input  logic [SRAM_AW:0]   i_addr,
   input  logic [31:0]        i_wdata,
   input  logic [3:0]         i_bmask,
   output logic               o_ready,
   output logic               o_ack,
   output logic [31:0]        o_rdata,
   output logic [SRAM_AW-1:0] o_sram_addr,
   output logic [15:0]        o_sram_dq,
   output logic               o_sram_dq_oe,
   input  logic [15:0]        i_sram_dq,
   output logic               o_sram_ce_n,
   output logic               o_sram_we_n,
   output logic               o_sram_oe_n,
   output logic               o_sram_lb_n,
   output logic               o_sram_ub_n
);

   localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

   sram_state_e        state, n_state;
   logic [2:0]         cnt, n_cnt;
   logic               wren, n_wren;
   logic [SRAM_AW-2:0] word_idx, n_idx;
   logic [31:0]        wdata, n_wdata;
   logic [3:0]         bmask, n_bmask;

   logic        take, in_ph, n_sel, last_rd;
   logic [1:0]  n_hm;
   logic [15:0] n_whalf;

   always_comb begin
      take    = (state == IDLE) && i_req;
      n_wren  = take ? i_wren          : wren;
      n_idx   = take ? i_addr[SRAM_AW:2] : word_idx;
      n_wdata = take ? i_wdata         : wdata;
      n_bmask = take ? i_bmask         : bmask;

      n_state = state;
      n_cnt   = cnt + 3'd1;
      case (state)
         IDLE: begin
            n_cnt = 3'd0;
            if (i_req)
               n_state = (|i_bmask[1:0]) ? LO : (|i_bmask[3:2]) ? HI : ACK;
         end
         LO: if (cnt == LAST) begin
            n_cnt   = 3'd0;
            n_state = (|bmask[3:2]) ? HI : ACK;
         end
         HI: if (cnt == LAST) begin
            n_cnt   = 3'd0;
            n_state = ACK;
         end
         ACK: begin
            n_cnt   = 3'd0;
            n_state = IDLE;
         end
         default: begin
            n_cnt   = 3'd0;
            n_state = IDLE;
         end
      endcase

      in_ph   = (n_state == LO) || (n_state == HI);
      n_sel   = (n_state == HI) ? HALF_HI : HALF_LO;
      n_hm    = n_sel ? n_bmask[3:2] : n_bmask[1:0];
      n_whalf = n_sel ? n_wdata[31:16] : n_wdata[15:0];
      // SRAM data is sampled at the end of the last strobe cycle of a read
      last_rd = ((state == LO) || (state == HI)) && !wren && (cnt == LAST);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         cnt          <= 3'd0;
         wren         <= 1'b0;
         word_idx     <= '0;
         wdata        <= '0;
         bmask        <= '0;
         o_ready      <= 1'b1;
         o_ack        <= 1'b0;
         o_rdata      <= '0;
         o_sram_addr  <= '0;
         o_sram_dq    <= '0;
         o_sram_dq_oe <= 1'b0;
         o_sram_ce_n  <= 1'b1;
         o_sram_we_n  <= 1'b1;
         o_sram_oe_n  <= 1'b1;
         o_sram_lb_n  <= 1'b1;
         o_sram_ub_n  <= 1'b1;
      end else begin
         state    <= n_state;
         cnt      <= n_cnt;
         wren     <= n_wren;
         word_idx <= n_idx;
         wdata    <= n_wdata;
         bmask    <= n_bmask;

         o_ready      <= (n_state == IDLE);
         o_ack        <= (n_state == ACK);
         o_sram_ce_n  <= ~in_ph;
         // we_n releases on the final phase cycle so address/data are held
         // past the write edge; addresses only move while we_n is high
         o_sram_we_n  <= ~(in_ph && n_wren && (n_cnt != LAST));
         o_sram_oe_n  <= ~(in_ph && !n_wren);
         o_sram_lb_n  <= ~(in_ph && n_hm[0]);
         o_sram_ub_n  <= ~(in_ph && n_hm[1]);
         o_sram_dq_oe <= in_ph && n_wren;
         if (in_ph)
            o_sram_addr <= {n_idx, n_sel};
         if (in_ph && n_wren)
            o_sram_dq <= n_whalf;

         // A new load clears rdata so skipped halves read back as zero;
         // stores leave it untouched.
         if (take && !i_wren)
            o_rdata <= '0;
         else if (last_rd) begin
            if (state == HI)
               o_rdata[31:16] <= i_sram_dq & {{8{bmask[3]}}, {8{bmask[2]}}};
            else
               o_rdata[15:0]  <= i_sram_dq & {{8{bmask[1]}}, {8{bmask[0]}}};
         end
      end
   end

endmodule
